mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Parametrised multicycle MIPS control unit: Moore FSM plus ALU decode, driving the multicycle datapath.
//  Adds optional memory wait states (mem_ready), extended ISA (bne/andi/ori/slti/jal), illegal-op detect/trap.
//  Sits between datapath (op/funct/zero) and datapath/memory control strobes.
// PARAMETERS
//  MEM_WAIT        0  1: FETCH/MEMRD/MEMWR hold until mem_ready=1; 0: mem_ready ignored (1-cycle memory)
//  EXT_ISA         1  1: bne, andi, ori, slti, jal legal; 0: those opcodes treated as illegal
//  TRAP_ILLEGAL    0  1: illegal op/funct enters HALT until reset; 0: pulse illegal, return to FETCH
// PORTS
//  clk         in   1  clock, all state on rising edge
//  reset       in   1  synchronous, active-high
//  op          in   6  instr[31:26]
//  funct       in   6  instr[5:0]
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  memory access complete (used only if MEM_WAIT=1)
//  pcen        out  1  PC load = pcwrite | (beq & zero) | (bne & ~zero)
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  regwrite    out  1  register file write
//  alusrca     out  1  0=PC, 1=A
//  iord        out  1  0=PC, 1=ALUOut as memory address
//  memtoreg    out  2  00=ALUOut, 01=Data, 10=PC (link)
//  regdst      out  2  00=rt, 01=rd, 10=r31
//  alusrcb     out  2  00=B, 01=4, 10=imm, 11=imm<<2
//  extop       out  1  0=sign-extend imm, 1=zero-extend (andi/ori)
//  pcsrc       out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal     out  1  1-cycle pulse on unsupported op/funct
//  halted      out  1  FSM in HALT
// BEHAVIOUR
//  Reset: state<=FETCH on clk edge with reset=1; all outputs combinationally 0 while reset=1; reset mid-instruction aborts it (no write).
//  States (4b): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 RTYPEEX6 RTYPEWB7 BEQEX8 IEX9 IWB10 JEX11 BNEEX12 JALEX13 HALT14.
//  FETCH: iord=0 alusrca=0 alusrcb=01 add pcsrc=00 irwrite=1 pcwrite=1; if MEM_WAIT & ~mem_ready: irwrite=pcwrite=0, stay.
//  DECODE: alusrca=0 alusrcb=11 add (branch target to ALUOut). Next by op: lw/sw(100011/101011)->MEMADR, 000000->RTYPEEX,
//   beq 000100->BEQEX, j 000010->JEX; EXT_ISA: bne 000101->BNEEX, jal 000011->JALEX; addi 001000, andi 001100, ori 001101, slti 001010 ->IEX
//   (addi always legal); else illegal=1 and ->HALT (TRAP_ILLEGAL) or FETCH.
//  MEMADR: alusrca=1 alusrcb=10 add; ->MEMRD (lw) / MEMWR (sw).
//  MEMRD: iord=1; ->MEMWB when (~MEM_WAIT | mem_ready). MEMWB: regwrite=1 regdst=00 memtoreg=01; ->FETCH.
//  MEMWR: iord=1 memwrite=1 held each cycle until (~MEM_WAIT | mem_ready); then ->FETCH.
//  RTYPEEX: alusrca=1 alusrcb=00, alucontrol from funct (100000 add,100010 sub,100100 and,100101 or,101010 slt);
//   other funct: illegal=1, alucontrol=010, ->HALT/FETCH, no writeback. Legal ->RTYPEWB: regwrite=1 regdst=01 memtoreg=00 ->FETCH.
//  BEQEX/BNEEX: alusrca=1 alusrcb=00 sub pcsrc=01; PC loads only on zero (beq) / ~zero (bne); ->FETCH.
//  IEX: alusrca=1 alusrcb=10; addi add/extop0, andi and/extop1, ori or/extop1, slti slt/extop0; ->IWB: regwrite=1 regdst=00 memtoreg=00 ->FETCH.
//  JEX: pcwrite=1 pcsrc=10 ->FETCH. JALEX: pcwrite=1 pcsrc=10 regwrite=1 regdst=10 memtoreg=10 (PC already +4) ->FETCH.
//  HALT: all strobes 0, halted=1, stay until reset. Unused state encoding 15 -> FETCH, all strobes 0.
//  Unlisted outputs 0 in every state; alucontrol=010 where not specified. op/funct sampled only in DECODE/MEMADR/RTYPEEX/IEX.
//  Cycle counts (MEM_WAIT=0): lw 5, sw 4, R-type 4, addi/andi/ori/slti 4, beq/bne 3, j/jal 3.
// TESTING
//  MEM_WAIT=0, lw op=100011 -> states 0,1,2,3,4; MEMWB regwrite=1 memtoreg=01; 5 cycles total.
//  MEM_WAIT=1, sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; FETCH with ready low holds irwrite=0.
//  bne op=000101 zero=0 -> pcen=1 pcsrc=01 in BNEEX; zero=1 -> pcen=0.
//  jal op=000011 -> JALEX: regwrite=1 regdst=10 memtoreg=10 pcsrc=10 pcen=1.
//  op=111111 TRAP_ILLEGAL=0 -> illegal pulse in DECODE, next FETCH; TRAP_ILLEGAL=1 -> HALT, halted=1 until reset.
//  reset=1 asserted in MEMWR -> memwrite=0 immediately; next edge state=FETCH; andi with EXT_ISA=0 -> illegal.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM + ALU decode).
// Drives the multicycle datapath strobes from op/funct/zero. It can optionally
// wait on memory (mem_ready), supports the extended ISA (bne/andi/ori/slti/jal),
// and flags unsupported op/funct values.
// Parameters: MEM_WAIT     - FETCH/MEMRD/MEMWR hold until mem_ready
//             EXT_ISA      - bne/andi/ori/slti/jal are legal
//             TRAP_ILLEGAL - an illegal instruction parks the FSM in HALT
// Inputs : clk, reset (sync, active-high), op[5:0], funct[5:0], zero, mem_ready
// Outputs: pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg[1:0],
//          regdst[1:0], alusrcb[1:0], extop, pcsrc[1:0], alucontrol[2:0],
//          illegal, halted
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | branch target into ALUOut, dispatch on op
// MEMADR   | effective address = A + imm
// MEMRD    | data read at ALUOut
// MEMWB    | load data into rt
// MEMWR    | store B at ALUOut
// RTYPEEX  | A op B, op chosen by funct
// RTYPEWB  | ALUOut into rd
// BEQEX    | compare, branch on equal
// IEX      | A op imm
// IWB      | ALUOut into rt
// JEX      | jump
// BNEEX    | compare, branch on not equal
// JALEX    | jump and link PC+4 into r31
// HALT     | trapped on illegal instruction until reset
module mc_controller #(
  parameter bit MEM_WAIT     = 1'b0,
  parameter bit EXT_ISA      = 1'b1,
  parameter bit TRAP_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic [1:0] memtoreg,
  output logic [1:0] regdst,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
    S_BEQEX = 4'd8, S_IEX = 4'd9, S_IWB = 4'd10, S_JEX = 4'd11,
    S_BNEEX = 4'd12, S_JALEX = 4'd13, S_HALT = 4'd14, S_UNUSED = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam state_t S_ILLEGAL_NEXT = TRAP_ILLEGAL ? S_HALT : S_FETCH;

  state_t state_q, state_d;
  logic   pcwrite, br_eq, br_ne, op_bad, mem_ok;

  // With MEM_WAIT=0 every memory access completes in one cycle.
  assign mem_ok = ~MEM_WAIT | mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    br_eq      = 1'b0;
    br_ne      = 1'b0;
    op_bad     = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 2'b00;
    regdst     = 2'b00;
    alusrcb    = 2'b00;
    extop      = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (mem_ok) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_IEX;
          OP_BNE:       if (EXT_ISA) state_d = S_BNEEX; else op_bad = 1'b1;
          OP_JAL:       if (EXT_ISA) state_d = S_JALEX; else op_bad = 1'b1;
          OP_ANDI, OP_ORI, OP_SLTI:
                        if (EXT_ISA) state_d = S_IEX; else op_bad = 1'b1;
          default:      op_bad = 1'b1;
        endcase
        if (op_bad) begin
          illegal = 1'b1;
          state_d = S_ILLEGAL_NEXT;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ok) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        state_d = S_RTYPEWB;
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_ILLEGAL_NEXT;
          end
        endcase
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
        state_d  = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        br_eq      = (state_q == S_BEQEX);
        br_ne      = (state_q == S_BNEEX);
        state_d    = S_FETCH;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_IWB;
        case (op)
          OP_ANDI: begin alucontrol = ALU_AND; extop = 1'b1; end
          OP_ORI:  begin alucontrol = ALU_OR;  extop = 1'b1; end
          OP_SLTI: alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        state_d = S_FETCH;
      end
      S_JALEX: begin
        pcwrite  = 1'b1;
        pcsrc    = 2'b10;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    pcen = pcwrite | (br_eq & zero) | (br_ne & ~zero);

    // Reset kills every strobe in the same cycle so an aborted store never writes.
    if (reset) begin
      pcen       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 2'b00;
      regdst     = 2'b00;
      alusrcb    = 2'b00;
      extop      = 1'b0;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      illegal    = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller. Three configurations are instantiated:
//   cfg0: MEM_WAIT=0 EXT_ISA=1 TRAP_ILLEGAL=0
//   cfg1: MEM_WAIT=1 EXT_ISA=1 TRAP_ILLEGAL=1
//   cfg2: MEM_WAIT=0 EXT_ISA=0 TRAP_ILLEGAL=0
// Each instruction is expanded into its list of micro-steps. Each step's
// expected strobes come from the instruction rules, and one negedge process
// compares the active DUT against them.
module tb_mc_controller;

  typedef struct packed {
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord;
    logic [1:0] memtoreg, regdst, alusrcb;
    logic       extop;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal, halted;
  } out_t;

  localparam int K_FETCH = 0, K_DEC = 1, K_ADR = 2, K_RD = 3, K_WB = 4, K_WR = 5,
                 K_REX = 6, K_RWB = 7, K_BR = 8, K_IEX = 9, K_IWB = 10, K_J = 11,
                 K_JAL = 12, K_HALT = 13, K_RST = 14;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                         BNE = 6'b000101, J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000,
                         ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [3];
  logic [5:0] op_i   [3];
  logic [5:0] fn_i   [3];
  logic       zero_i [3];
  logic       rdy_i  [3];
  logic       chk    [3];
  out_t       dv     [3];
  out_t       ex     [3];

  int n_cmp = 0;
  int n_bad = 0;
  out_t trace[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, extop, illegal, halted;
    logic [1:0] memtoreg, regdst, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    mc_controller #(
      .MEM_WAIT(g == 1), .EXT_ISA(g != 2), .TRAP_ILLEGAL(g == 1)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .op(op_i[g]), .funct(fn_i[g]), .zero(zero_i[g]),
      .mem_ready(rdy_i[g]), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
      .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
      .regdst(regdst), .alusrcb(alusrcb), .extop(extop), .pcsrc(pcsrc),
      .alucontrol(alucontrol), .illegal(illegal), .halted(halted)
    );
    assign dv[g] = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                    alusrcb, extop, pcsrc, alucontrol, illegal, halted};
  end

  function automatic bit op_legal(logic [5:0] o, bit ext);
    if (o == LW || o == SW || o == RT || o == BEQ || o == J || o == ADDI) return 1'b1;
    if (ext && (o == BNE || o == JAL || o == ANDI || o == ORI || o == SLTI)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit fn_legal(logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic logic [2:0] fn_alu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected strobes for one micro-step of an instruction.
  function automatic out_t model(int kind, logic [5:0] iop, logic [5:0] ifn,
                                 logic z, logic rdy, bit mw, bit ext);
    out_t o = '0;
    if (kind == K_RST) return o;
    o.alucontrol = 3'b010;
    case (kind)
      K_FETCH: begin
        o.alusrcb = 2'b01;
        if (!mw || rdy) begin o.irwrite = 1'b1; o.pcen = 1'b1; end
      end
      K_DEC:  begin o.alusrcb = 2'b11; o.illegal = !op_legal(iop, ext); end
      K_ADR:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      K_RD:   o.iord = 1'b1;
      K_WB:   begin o.regwrite = 1'b1; o.memtoreg = 2'b01; end
      K_WR:   begin o.iord = 1'b1; o.memwrite = 1'b1; end
      K_REX: begin
        o.alusrca = 1'b1;
        if (fn_legal(ifn)) o.alucontrol = fn_alu(ifn);
        else o.illegal = 1'b1;
      end
      K_RWB:  begin o.regwrite = 1'b1; o.regdst = 2'b01; end
      K_BR: begin
        o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
        o.pcen = (iop == BEQ) ? z : !z;
      end
      K_IEX: begin
        o.alusrca = 1'b1; o.alusrcb = 2'b10;
        if (iop == ANDI)      begin o.alucontrol = 3'b000; o.extop = 1'b1; end
        else if (iop == ORI)  begin o.alucontrol = 3'b001; o.extop = 1'b1; end
        else if (iop == SLTI) o.alucontrol = 3'b111;
      end
      K_IWB:  o.regwrite = 1'b1;
      K_J:    begin o.pcen = 1'b1; o.pcsrc = 2'b10; end
      K_JAL: begin
        o.pcen = 1'b1; o.pcsrc = 2'b10; o.regwrite = 1'b1;
        o.regdst = 2'b10; o.memtoreg = 2'b10;
      end
      K_HALT: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (chk[k]) begin
        n_cmp++;
        if (dv[k] !== ex[k]) begin
          n_bad++;
          $display("FAIL cfg%0d strobes @%0t: got %h expected %h", k, $time, dv[k], ex[k]);
        end
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // nf/nm: memory wait cycles (-1 random); zmode: -1 random zero, else fixed;
  // abort_at: -1 none, -2 random step, else step index replaced by reset.
  task automatic run_instr(input int k, input logic [5:0] iop, input logic [5:0] ifn,
                           input int zmode, input int nf_in, input int nm_in,
                           input int abort_at);
    bit mw   = (k == 1);
    bit ext  = (k != 2);
    bit trap = (k == 1);
    int kinds[$];
    bit rq[$];
    int nf, nm, ab;
    nf = mw ? ((nf_in >= 0) ? nf_in : int'($urandom_range(0, 2))) : 0;
    nm = mw ? ((nm_in >= 0) ? nm_in : int'($urandom_range(0, 2))) : 0;
    for (int i = 0; i < nf; i++) begin kinds.push_back(K_FETCH); rq.push_back(1'b0); end
    kinds.push_back(K_FETCH); rq.push_back(mw ? 1'b1 : 1'($urandom));
    kinds.push_back(K_DEC);   rq.push_back(1'($urandom));
    if (!op_legal(iop, ext)) begin
      if (trap) begin
        repeat (3) begin kinds.push_back(K_HALT); rq.push_back(1'($urandom)); end
        kinds.push_back(K_RST); rq.push_back(1'b0);
      end
    end else if (iop == LW || iop == SW) begin
      kinds.push_back(K_ADR); rq.push_back(1'($urandom));
      for (int i = 0; i < nm; i++) begin
        kinds.push_back(iop == LW ? K_RD : K_WR); rq.push_back(1'b0);
      end
      kinds.push_back(iop == LW ? K_RD : K_WR); rq.push_back(mw ? 1'b1 : 1'($urandom));
      if (iop == LW) begin kinds.push_back(K_WB); rq.push_back(1'($urandom)); end
    end else if (iop == RT) begin
      kinds.push_back(K_REX); rq.push_back(1'($urandom));
      if (fn_legal(ifn)) begin
        kinds.push_back(K_RWB); rq.push_back(1'($urandom));
      end else if (trap) begin
        repeat (3) begin kinds.push_back(K_HALT); rq.push_back(1'($urandom)); end
        kinds.push_back(K_RST); rq.push_back(1'b0);
      end
    end else if (iop == BEQ || iop == BNE) begin
      kinds.push_back(K_BR); rq.push_back(1'($urandom));
    end else if (iop == J) begin
      kinds.push_back(K_J); rq.push_back(1'($urandom));
    end else if (iop == JAL) begin
      kinds.push_back(K_JAL); rq.push_back(1'($urandom));
    end else begin
      kinds.push_back(K_IEX); rq.push_back(1'($urandom));
      kinds.push_back(K_IWB); rq.push_back(1'($urandom));
    end

    ab = (abort_at == -2) ? int'($urandom_range(0, kinds.size() - 1)) : abort_at;
    if (ab >= 0 && ab < kinds.size()) begin
      while (kinds.size() > ab) begin void'(kinds.pop_back()); void'(rq.pop_back()); end
      kinds.push_back(K_RST); rq.push_back(1'b0);
    end

    trace.delete();
    for (int i = 0; i < kinds.size(); i++) begin
      logic z;
      bit samp;
      z    = (zmode < 0) ? 1'($urandom) : zmode[0];
      samp = (kinds[i] == K_DEC || kinds[i] == K_ADR || kinds[i] == K_REX || kinds[i] == K_IEX);
      @(posedge clk);
      #1;
      rst[k]    = (kinds[i] == K_RST);
      op_i[k]   = samp ? iop : 6'($urandom);
      fn_i[k]   = samp ? ifn : 6'($urandom);
      zero_i[k] = z;
      rdy_i[k]  = rq[i];
      ex[k]     = model(kinds[i], iop, ifn, z, rq[i], mw, ext);
      chk[k]    = 1'b1;
      @(negedge clk);
      trace.push_back(dv[k]);
    end
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 12))
      0: return LW;   1: return SW;   2: return RT;   3: return BEQ;
      4: return BNE;  5: return J;    6: return JAL;  7: return ADDI;
      8: return ANDI; 9: return ORI;  10: return SLTI;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_fn();
    case ($urandom_range(0, 6))
      0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
      3: return 6'b100101; 4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic reset_cycle(input int k);
    @(posedge clk);
    #1;
    rst[k]  = 1'b1;
    ex[k]   = '0;
    chk[k]  = 1'b1;
    rdy_i[k] = 1'b1;
    @(negedge clk);
  endtask

  task automatic park(input int k);
    @(posedge clk);
    #1;
    chk[k] = 1'b0;
    rst[k] = 1'b1;
  endtask

  initial begin
    out_t lit;
    int   nmw;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; op_i[k] = '0; fn_i[k] = '0; zero_i[k] = 1'b0;
      rdy_i[k] = 1'b0; chk[k] = 1'b0; ex[k] = '0;
    end
    repeat (2) @(posedge clk);

    // cfg0: MEM_WAIT=0, EXT_ISA=1, TRAP_ILLEGAL=0
    reset_cycle(0);
    run_instr(0, LW, 6'd0, -1, -1, -1, -1);
    lit = '0; lit.alucontrol = 3'b010; lit.alusrcb = 2'b01; lit.irwrite = 1'b1; lit.pcen = 1'b1;
    check_lit("lw_fetch", int'(trace[0]), int'(lit));
    lit = '0; lit.alucontrol = 3'b010; lit.alusrca = 1'b1; lit.alusrcb = 2'b10;
    check_lit("lw_memadr", int'(trace[2]), int'(lit));
    lit = '0; lit.alucontrol = 3'b010; lit.regwrite = 1'b1; lit.memtoreg = 2'b01;
    check_lit("lw_memwb", int'(trace[4]), int'(lit));
    run_instr(0, BNE, 6'd0, 0, -1, -1, -1);
    check_lit("bne_nz_pcen", int'(trace[2].pcen), 1);
    check_lit("bne_nz_pcsrc", int'(trace[2].pcsrc), 1);
    run_instr(0, BNE, 6'd0, 1, -1, -1, -1);
    check_lit("bne_z_pcen", int'(trace[2].pcen), 0);
    run_instr(0, JAL, 6'd0, -1, -1, -1, -1);
    lit = '0; lit.alucontrol = 3'b010; lit.pcen = 1'b1; lit.pcsrc = 2'b10;
    lit.regwrite = 1'b1; lit.regdst = 2'b10; lit.memtoreg = 2'b10;
    check_lit("jal_jalex", int'(trace[2]), int'(lit));
    run_instr(0, 6'b111111, 6'd0, -1, -1, -1, -1);
    check_lit("illegal_pulse", int'(trace[1].illegal), 1);
    run_instr(0, SW, 6'd0, -1, -1, -1, -1);
    check_lit("after_illegal_fetch", int'(trace[0].irwrite), 1);
    for (int n = 0; n < 300; n++) run_instr(0, rand_op(), rand_fn(), -1, -1, -1, -1);
    park(0);

    // cfg1: MEM_WAIT=1, EXT_ISA=1, TRAP_ILLEGAL=1
    reset_cycle(1);
    run_instr(1, SW, 6'd0, -1, 2, 3, -1);
    check_lit("fetch_wait_irwrite", int'(trace[0].irwrite), 0);
    check_lit("fetch_ready_irwrite", int'(trace[2].irwrite), 1);
    nmw = 0;
    foreach (trace[i]) nmw += int'(trace[i].memwrite);
    check_lit("sw_memwrite_cycles", nmw, 4);
    run_instr(1, SW, 6'd0, -1, 0, 3, 4);
    check_lit("sw_before_abort", int'(trace[3].memwrite), 1);
    check_lit("sw_abort_all_zero", int'(trace[4]), 0);
    run_instr(1, 6'b111111, 6'd0, -1, 0, -1, -1);
    check_lit("trap_illegal", int'(trace[1].illegal), 1);
    check_lit("trap_halted", int'(trace[2].halted), 1);
    check_lit("trap_still_halted", int'(trace[4].halted), 1);
    for (int n = 0; n < 300; n++)
      run_instr(1, rand_op(), rand_fn(), -1, -1, -1, ($urandom_range(0, 7) == 0) ? -2 : -1);
    park(1);

    // cfg2: MEM_WAIT=0, EXT_ISA=0, TRAP_ILLEGAL=0
    reset_cycle(2);
    run_instr(2, ANDI, 6'd0, -1, -1, -1, -1);
    check_lit("andi_noext_illegal", int'(trace[1].illegal), 1);
    for (int n = 0; n < 300; n++)
      run_instr(2, rand_op(), rand_fn(), -1, -1, -1, ($urandom_range(0, 9) == 0) ? -2 : -1);
    park(2);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
